regbank_mp: RTL and testbench



---
 rtl/regbank_mp_if.sv | 47 ++++
 rtl/regbank_mp.sv | 145 ++++++++++++++
 tb/tb_regbank_mp.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/regbank_mp_if.sv
// Register bank bus: two combinational read ports, two write ports and a reservation port.
// The master modport drives addresses, writes and reservations; the slave modport is the bank.
interface regbank_mp_if #(
    parameter int WIDTH   = 32,
    parameter int REG_SEL = 5
);
    logic               rd_a_sel;
    logic [REG_SEL-1:0] rd_a_addr;
    logic [WIDTH-1:0]   rd_a_data;
    logic               rd_a_busy;

    logic               rd_b_sel;
    logic [REG_SEL-1:0] rd_b_addr;
    logic [WIDTH-1:0]   rd_b_data;
    logic               rd_b_busy;

    logic               wr0_en;
    logic               wr0_sel;
    logic [REG_SEL-1:0] wr0_addr;
    logic [WIDTH-1:0]   wr0_data;

    logic               wr1_en;
    logic               wr1_sel;
    logic [REG_SEL-1:0] wr1_addr;
    logic [WIDTH-1:0]   wr1_data;

    logic               rsv_en;
    logic               rsv_sel;
    logic [REG_SEL-1:0] rsv_addr;
    logic               rsv_ok;

    modport master (
        output rd_a_sel, rd_a_addr, rd_b_sel, rd_b_addr,
        output wr0_en, wr0_sel, wr0_addr, wr0_data,
        output wr1_en, wr1_sel, wr1_addr, wr1_data,
        output rsv_en, rsv_sel, rsv_addr,
        input  rd_a_data, rd_a_busy, rd_b_data, rd_b_busy, rsv_ok
    );

    modport slave (
        input  rd_a_sel, rd_a_addr, rd_b_sel, rd_b_addr,
        input  wr0_en, wr0_sel, wr0_addr, wr0_data,
        input  wr1_en, wr1_sel, wr1_addr, wr1_data,
        input  rsv_en, rsv_sel, rsv_addr,
        output rd_a_data, rd_a_busy, rd_b_data, rd_b_busy, rsv_ok
    );
endinterface

// File: rtl/regbank_mp.sv
// Multi-ported scalar/predicate register bank with per-register busy scoreboard.
// Reads are 0-cycle combinational, writes/reservations commit on the clk edge; no backpressure.
module regbank_mp #(
    parameter int WIDTH         = 32,
    parameter int NUM_REGS      = 32,
    parameter int NUM_PRED_REGS = 8,
    parameter int REG_SEL       = 5,
    parameter int PRED_REG_SEL  = 3,
    parameter int BYPASS        = 1,
    parameter int ZERO_REG      = 1
) (
    input  logic         clk,
    input  logic         reset,
    regbank_mp_if.slave  bus
);

    localparam logic [REG_SEL:0] REG_LIMIT  = (REG_SEL+1)'(NUM_REGS);
    localparam logic [REG_SEL:0] PRED_LIMIT = (REG_SEL+1)'(NUM_PRED_REGS);

    logic [WIDTH-1:0]         regs_q [NUM_REGS];
    logic [WIDTH-1:0]         regs_d [NUM_REGS];
    logic [NUM_PRED_REGS-1:0] preds_q, preds_d;
    logic [NUM_REGS-1:0]      sbusy_q, sbusy_d;
    logic [NUM_PRED_REGS-1:0] pbusy_q, pbusy_d;

    logic                     rd_sel  [2];
    logic [REG_SEL-1:0]       rd_addr [2];
    logic [WIDTH-1:0]         rd_dat  [2];
    logic                     rd_bsy  [2];

    logic                     wr_en   [2];
    logic                     wr_sel  [2];
    logic [REG_SEL-1:0]       wr_addr [2];
    logic [WIDTH-1:0]         wr_dat  [2];

    logic                     rsv_busy;

    // A target is real storage: in range for its bank and not the hardwired scalar r0.
    function automatic logic tgt_ok(input logic sel, input logic [REG_SEL-1:0] addr);
        if (sel) begin
            return ({1'b0, addr} < PRED_LIMIT);
        end
        return ({1'b0, addr} < REG_LIMIT) && !((ZERO_REG != 0) && (addr == '0));
    endfunction

    function automatic logic [WIDTH-1:0] zext(input logic b);
        return {{(WIDTH-1){1'b0}}, b};
    endfunction

    assign rd_sel[0]  = bus.rd_a_sel;
    assign rd_addr[0] = bus.rd_a_addr;
    assign rd_sel[1]  = bus.rd_b_sel;
    assign rd_addr[1] = bus.rd_b_addr;

    assign wr_en[0]   = bus.wr0_en;
    assign wr_sel[0]  = bus.wr0_sel;
    assign wr_addr[0] = bus.wr0_addr;
    assign wr_dat[0]  = bus.wr0_data;
    assign wr_en[1]   = bus.wr1_en;
    assign wr_sel[1]  = bus.wr1_sel;
    assign wr_addr[1] = bus.wr1_addr;
    assign wr_dat[1]  = bus.wr1_data;

    // Port 1 is applied after port 0 so it wins a same-address collision;
    // the reservation is applied last so it wins over a same-cycle write clear.
    always_comb begin
        regs_d  = regs_q;
        preds_d = preds_q;
        sbusy_d = sbusy_q;
        pbusy_d = pbusy_q;
        for (int w = 0; w < 2; w++) begin
            if (wr_en[w] && tgt_ok(wr_sel[w], wr_addr[w])) begin
                if (wr_sel[w]) begin
                    preds_d[wr_addr[w][PRED_REG_SEL-1:0]] = wr_dat[w][0];
                    pbusy_d[wr_addr[w][PRED_REG_SEL-1:0]] = 1'b0;
                end else begin
                    regs_d[wr_addr[w]]  = wr_dat[w];
                    sbusy_d[wr_addr[w]] = 1'b0;
                end
            end
        end
        if (bus.rsv_en && tgt_ok(bus.rsv_sel, bus.rsv_addr)) begin
            if (bus.rsv_sel) begin
                pbusy_d[bus.rsv_addr[PRED_REG_SEL-1:0]] = 1'b1;
            end else begin
                sbusy_d[bus.rsv_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            preds_q <= '0;
            sbusy_q <= '0;
            pbusy_q <= '0;
        end else begin
            regs_q  <= regs_d;
            preds_q <= preds_d;
            sbusy_q <= sbusy_d;
            pbusy_q <= pbusy_d;
        end
    end

    // Busy always reflects pre-edge state; only data is forwarded from same-cycle writes.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_dat[p] = '0;
            rd_bsy[p] = 1'b0;
            if (tgt_ok(rd_sel[p], rd_addr[p])) begin
                if (rd_sel[p]) begin
                    rd_dat[p] = zext(preds_q[rd_addr[p][PRED_REG_SEL-1:0]]);
                    rd_bsy[p] = pbusy_q[rd_addr[p][PRED_REG_SEL-1:0]];
                end else begin
                    rd_dat[p] = regs_q[rd_addr[p]];
                    rd_bsy[p] = sbusy_q[rd_addr[p]];
                end
                if (BYPASS != 0) begin
                    for (int w = 0; w < 2; w++) begin
                        if (wr_en[w] && (wr_sel[w] == rd_sel[p]) && (wr_addr[w] == rd_addr[p])) begin
                            rd_dat[p] = wr_sel[w] ? zext(wr_dat[w][0]) : wr_dat[w];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rsv_busy = 1'b0;
        if (tgt_ok(bus.rsv_sel, bus.rsv_addr)) begin
            rsv_busy = bus.rsv_sel ? pbusy_q[bus.rsv_addr[PRED_REG_SEL-1:0]]
                                   : sbusy_q[bus.rsv_addr];
        end
    end

    assign bus.rd_a_data = rd_dat[0];
    assign bus.rd_a_busy = rd_bsy[0];
    assign bus.rd_b_data = rd_dat[1];
    assign bus.rd_b_busy = rd_bsy[1];
    assign bus.rsv_ok    = !rsv_busy;

endmodule

// File: tb/tb_regbank_mp.sv
// Directed table-driven bench for regbank_mp (BYPASS=1, ZERO_REG=1).
module tb_regbank_mp;

    logic clk;
    logic reset;

    regbank_mp_if #(.WIDTH(32), .REG_SEL(5)) bus ();

    regbank_mp #(
        .WIDTH(32), .NUM_REGS(32), .NUM_PRED_REGS(8), .REG_SEL(5),
        .PRED_REG_SEL(3), .BYPASS(1), .ZERO_REG(1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        w0_en; logic w0_sel; logic [4:0] w0_addr; logic [31:0] w0_dat;
        logic        w1_en; logic w1_sel; logic [4:0] w1_addr; logic [31:0] w1_dat;
        logic        r_en;  logic r_sel;  logic [4:0] r_addr;
        logic        a_sel; logic [4:0] a_addr;
        logic        b_sel; logic [4:0] b_addr;
        logic [31:0] ea_dat; logic ea_bsy;
        logic [31:0] eb_dat; logic eb_bsy;
        logic        e_ok;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(
        input logic w0e, input logic w0s, input logic [4:0] w0a, input logic [31:0] w0d,
        input logic w1e, input logic w1s, input logic [4:0] w1a, input logic [31:0] w1d,
        input logic re,  input logic rs,  input logic [4:0] ra,
        input logic as_, input logic [4:0] aa, input logic bs, input logic [4:0] ba,
        input logic [31:0] ead, input logic eab, input logic [31:0] ebd, input logic ebb,
        input logic eok);
        vec_t v;
        v.w0_en = w0e; v.w0_sel = w0s; v.w0_addr = w0a; v.w0_dat = w0d;
        v.w1_en = w1e; v.w1_sel = w1s; v.w1_addr = w1a; v.w1_dat = w1d;
        v.r_en = re; v.r_sel = rs; v.r_addr = ra;
        v.a_sel = as_; v.a_addr = aa; v.b_sel = bs; v.b_addr = ba;
        v.ea_dat = ead; v.ea_bsy = eab; v.eb_dat = ebd; v.eb_bsy = ebb; v.e_ok = eok;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.wr0_en = 0; bus.wr0_sel = 0; bus.wr0_addr = '0; bus.wr0_data = '0;
        bus.wr1_en = 0; bus.wr1_sel = 0; bus.wr1_addr = '0; bus.wr1_data = '0;
        bus.rsv_en = 0; bus.rsv_sel = 0; bus.rsv_addr = '0;
        bus.rd_a_sel = 0; bus.rd_a_addr = '0; bus.rd_b_sel = 0; bus.rd_b_addr = '0;
    endtask

    initial begin
        //       w0: en sel addr data        w1: en sel addr data   rsv: en sel addr  A: sel addr  B: sel addr  expA data bsy  expB data bsy  ok
        vecs.push_back(mk(1,0,5,32'hDEADBEEF, 0,0,0,0, 0,0,0,  0,5,  1,5,  32'hDEADBEEF,0, 32'h0,0,        1)); // 0 bypass r5
        vecs.push_back(mk(0,0,0,0,            0,0,0,0, 0,0,0,  0,5,  0,7,  32'hDEADBEEF,0, 32'h0,0,        1)); // 1 r5 stored
        vecs.push_back(mk(1,0,7,32'h11,       1,0,7,32'h22, 0,0,0, 0,7, 0,5, 32'h22,0, 32'hDEADBEEF,0,     1)); // 2 collision
        vecs.push_back(mk(0,0,0,0,            0,0,0,0, 0,0,0,  0,7,  1,3,  32'h22,0,       32'h0,0,        1)); // 3 wr1 won
        vecs.push_back(mk(1,1,3,32'hFFFFFFFE, 0,0,0,0, 0,0,0,  1,3,  0,3,  32'h0,0,        32'h0,0,        1)); // 4 pred bit0=0
        vecs.push_back(mk(0,0,0,0,            0,0,0,0, 0,0,0,  1,3,  0,3,  32'h0,0,        32'h0,0,        1)); // 5
        vecs.push_back(mk(0,0,0,0,            1,1,3,32'h1, 0,0,0, 0,3, 1,3, 32'h0,0,       32'h1,0,        1)); // 6 pred bypass
        vecs.push_back(mk(0,0,0,0,            0,0,0,0, 0,0,0,  1,3,  0,3,  32'h1,0,        32'h0,0,        1)); // 7
        vecs.push_back(mk(1,0,0,32'h5,        0,0,0,0, 1,0,0,  0,0,  0,5,  32'h0,0,        32'hDEADBEEF,0, 1)); // 8 r0 write+rsv
        vecs.push_back(mk(0,0,0,0,            0,0,0,0, 0,0,0,  0,0,  0,0,  32'h0,0,        32'h0,0,        1)); // 9 r0 still zero
        vecs.push_back(mk(0,0,0,0,            0,0,0,0, 1,0,9,  0,9,  0,5,  32'h0,0,        32'hDEADBEEF,0, 1)); // 10 reserve r9
        vecs.push_back(mk(0,0,0,0,            0,0,0,0, 0,0,9,  0,9,  0,5,  32'h0,1,        32'hDEADBEEF,0, 0)); // 11 r9 busy
        vecs.push_back(mk(1,0,9,32'h99,       0,0,0,0, 1,0,9,  0,9,  0,9,  32'h99,1,       32'h99,1,       0)); // 12 write+rsv
        vecs.push_back(mk(0,0,0,0,            0,0,0,0, 0,0,9,  0,9,  0,7,  32'h99,1,       32'h22,0,       0)); // 13 rsv won
        vecs.push_back(mk(0,0,0,0,            1,0,9,32'hAB, 0,0,9, 0,9, 0,5, 32'hAB,1,     32'hDEADBEEF,0, 0)); // 14 write clears
        vecs.push_back(mk(0,0,0,0,            0,0,0,0, 0,0,9,  0,9,  0,7,  32'hAB,0,       32'h22,0,       1)); // 15 busy gone
        vecs.push_back(mk(1,1,12,32'h1,       0,0,0,0, 1,1,12, 1,12, 1,4,  32'h0,0,        32'h0,0,        1)); // 16 pred out of range
        vecs.push_back(mk(0,0,0,0,            0,0,0,0, 0,1,4,  1,12, 1,4,  32'h0,0,        32'h0,0,        1)); // 17 no alias to p4
        vecs.push_back(mk(0,0,0,0,            0,0,0,0, 1,1,2,  1,2,  0,2,  32'h0,0,        32'h0,0,        1)); // 18 reserve p2
        vecs.push_back(mk(0,0,0,0,            0,0,0,0, 0,1,2,  1,2,  0,2,  32'h0,1,        32'h0,0,        0)); // 19 p2 busy, r2 not
        vecs.push_back(mk(1,1,0,32'h1,        0,0,0,0, 0,0,0,  1,0,  0,0,  32'h1,0,        32'h0,0,        1)); // 20 p0 not special
        vecs.push_back(mk(0,0,0,0,            0,0,0,0, 0,0,0,  1,0,  1,3,  32'h1,0,        32'h1,0,        1)); // 21

        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Post-reset sweep over both banks.
        for (int i = 1; i < 32; i++) begin
            bus.rd_a_sel = 0; bus.rd_a_addr = 5'(i);
            #1;
            check($sformatf("reset r%0d data", i), bus.rd_a_data, 32'h0);
            check($sformatf("reset r%0d busy", i), 32'(bus.rd_a_busy), 32'h0);
        end
        for (int i = 0; i < 8; i++) begin
            bus.rd_b_sel = 1; bus.rd_b_addr = 5'(i);
            #1;
            check($sformatf("reset p%0d data", i), bus.rd_b_data, 32'h0);
            check($sformatf("reset p%0d busy", i), 32'(bus.rd_b_busy), 32'h0);
        end

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.wr0_en = vecs[i].w0_en; bus.wr0_sel = vecs[i].w0_sel;
            bus.wr0_addr = vecs[i].w0_addr; bus.wr0_data = vecs[i].w0_dat;
            bus.wr1_en = vecs[i].w1_en; bus.wr1_sel = vecs[i].w1_sel;
            bus.wr1_addr = vecs[i].w1_addr; bus.wr1_data = vecs[i].w1_dat;
            bus.rsv_en = vecs[i].r_en; bus.rsv_sel = vecs[i].r_sel; bus.rsv_addr = vecs[i].r_addr;
            bus.rd_a_sel = vecs[i].a_sel; bus.rd_a_addr = vecs[i].a_addr;
            bus.rd_b_sel = vecs[i].b_sel; bus.rd_b_addr = vecs[i].b_addr;
            #1;
            check($sformatf("v%0d rd_a_data", i), bus.rd_a_data, vecs[i].ea_dat);
            check($sformatf("v%0d rd_a_busy", i), 32'(bus.rd_a_busy), 32'(vecs[i].ea_bsy));
            check($sformatf("v%0d rd_b_data", i), bus.rd_b_data, vecs[i].eb_dat);
            check($sformatf("v%0d rd_b_busy", i), 32'(bus.rd_b_busy), 32'(vecs[i].eb_bsy));
            check($sformatf("v%0d rsv_ok", i), 32'(bus.rsv_ok), 32'(vecs[i].e_ok));
        end

        // Reserve r9 again, then reset while busy; writes/reservations in the reset cycle are dropped.
        @(negedge clk);
        idle_inputs();
        bus.rsv_en = 1; bus.rsv_addr = 5'd9;
        @(negedge clk);
        idle_inputs();
        bus.rd_a_addr = 5'd9;
        #1;
        check("pre-reset r9 busy", 32'(bus.rd_a_busy), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        bus.wr0_en = 1; bus.wr0_addr = 5'd10; bus.wr0_data = 32'h55;
        bus.rsv_en = 1; bus.rsv_addr = 5'd10;
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        bus.rd_a_addr = 5'd9; bus.rd_b_addr = 5'd10; bus.rsv_addr = 5'd9;
        #1;
        check("post-reset r9 busy", 32'(bus.rd_a_busy), 32'h0);
        check("post-reset r9 data", bus.rd_a_data, 32'h0);
        check("post-reset r10 data", bus.rd_b_data, 32'h0);
        check("post-reset r10 busy", 32'(bus.rd_b_busy), 32'h0);
        check("post-reset rsv_ok r9", 32'(bus.rsv_ok), 32'h1);
        bus.rd_a_addr = 5'd7; bus.rd_b_sel = 1; bus.rd_b_addr = 5'd3;
        #1;
        check("post-reset r7 data", bus.rd_a_data, 32'h0);
        check("post-reset p3 data", bus.rd_b_data, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
